// File: rtl/rbus_pkg.sv
// rbus_pkg: register-bus codes and the read-encoder state type, shared with the write decoder.
package rbus_pkg;
  localparam logic [4:0] CODE_NONE = 5'd0;
  localparam logic [4:0] CODE_ALL = 5'd31;
  localparam int NUM_SRC_DEF = 19;
  localparam logic [4:0] CODE_R1 = 5'd1;
  localparam logic [4:0] CODE_R2 = 5'd2;
  localparam logic [4:0] CODE_R3 = 5'd3;
  localparam logic [4:0] CODE_R4 = 5'd4;
  localparam logic [4:0] CODE_R5 = 5'd5;
  localparam logic [4:0] CODE_R6 = 5'd6;
  localparam logic [4:0] CODE_R7 = 5'd7;
  localparam logic [4:0] CODE_R8 = 5'd8;
  localparam logic [4:0] CODE_R9 = 5'd9;
  localparam logic [4:0] CODE_R10 = 5'd10;
  localparam logic [4:0] CODE_R11 = 5'd11;
  localparam logic [4:0] CODE_R12 = 5'd12;
  localparam logic [4:0] CODE_R13 = 5'd13;
  localparam logic [4:0] CODE_R14 = 5'd14;
  localparam logic [4:0] CODE_PC = 5'd15;
  localparam logic [4:0] CODE_TOTR = 5'd16;
  localparam logic [4:0] CODE_MDDR = 5'd17;
  localparam logic [4:0] CODE_TR = 5'd18;
  localparam logic [4:0] CODE_AR = 5'd19;
  typedef enum logic [1:0] {IDLE, ENCODE, DRIVE} state_t;
endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc: lowest-set-bit encoder giving code = index+1, plus zero/multi-hot/all-ones flags.
module onehot_prio_enc import rbus_pkg::*; #(
  parameter int N = NUM_SRC_DEF
) (
  input  logic [N-1:0] i_vec,
  output logic [4:0]   o_code,
  output logic         o_zero,
  output logic         o_multi,
  output logic         o_all_ones
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] w_idx;
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_vec[i]) w_idx = IW'(i);
  end
  assign o_zero = ~|i_vec;
  // clearing the lowest set bit leaves something only when two or more bits were set
  assign o_multi = |(i_vec & (i_vec - N'(1)));
  assign o_all_ones = &i_vec;
  assign o_code = o_zero ? CODE_NONE : 5'(w_idx) + 5'd1;
endmodule

// File: rtl/rbus_read_enc.sv
// rbus_read_enc: encodes a one-hot read request, selects the source register and drives it
// onto the internal read bus with a valid/ack handshake; flags malformed requests.
module rbus_read_enc import rbus_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [NUM_SRC-1:0]        rd_req,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [DATA_W-1:0]         bus_out,
  output logic [4:0]                bus_code,
  output logic                      bus_valid,
  input  logic                      bus_ack,
  output logic                      req_err
);
  localparam int IW = $clog2(NUM_SRC);
  // codes 1..NUM_SRC must never collide with the write-only broadcast code 31
  if (NUM_SRC > 30) begin : g_bad_num_src
    $error("rbus_read_enc: NUM_SRC must be <= 30");
  end
  state_t r_state;
  logic [NUM_SRC-1:0] r_req;
  logic [4:0] w_code;
  logic w_zero, w_multi, w_all;
  logic [IW-1:0] w_sel;
  onehot_prio_enc #(.N(NUM_SRC)) u_enc (
    .i_vec(r_req),
    .o_code(w_code),
    .o_zero(w_zero),
    .o_multi(w_multi),
    .o_all_ones(w_all)
  );
  assign rd_ready = r_state == IDLE;
  assign w_sel = IW'(w_code - 5'd1);
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_req <= '0;
      bus_out <= '0;
      bus_code <= CODE_NONE;
      bus_valid <= 1'b0;
      req_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (rd_valid) begin
          r_req <= rd_req;
          r_state <= ENCODE;
        end
        ENCODE: begin
          req_err <= w_zero | w_multi;
          if (w_zero || w_all) r_state <= IDLE;
          else begin
            r_state <= DRIVE;
            bus_out <= src_data[32'(w_sel) * DATA_W +: DATA_W];
            bus_code <= w_code;
            bus_valid <= 1'b1;
          end
        end
        DRIVE: if (bus_ack) begin
          bus_valid <= 1'b0;
          bus_code <= CODE_NONE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rbus_read_enc.sv
// tb_rbus_read_enc: table-driven read requests with a scoreboard of expected bus words,
// plus hand-written throughput and asynchronous-reset sequences.
module tb_rbus_read_enc;
  localparam int DW = 16;
  localparam int NS = 19;
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic [NS-1:0] rd_req = '0;
  logic rd_valid = 1'b0;
  logic rd_ready;
  logic [NS*DW-1:0] src_data = '0;
  logic [DW-1:0] bus_out;
  logic [4:0] bus_code;
  logic bus_valid;
  logic bus_ack = 1'b0;
  logic req_err;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [NS-1:0] req;
    logic [DW-1:0] dat;
    int ack_dly;
    logic [4:0] code;
    logic err;
    logic bus;
  } vec_t;
  typedef struct {
    logic [4:0] code;
    logic [DW-1:0] data;
    logic err;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[8];
  rbus_read_enc #(.DATA_W(DW), .NUM_SRC(NS)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .rd_req(rd_req),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .src_data(src_data),
    .bus_out(bus_out),
    .bus_code(bus_code),
    .bus_valid(bus_valid),
    .bus_ack(bus_ack),
    .req_err(req_err)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic fill_src();
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = 16'($urandom);
  endtask
  function automatic logic [DW-1:0] slice(input logic [4:0] code);
    return src_data[(int'(code) - 1) * DW +: DW];
  endfunction
  task automatic run_vec(input vec_t v);
    exp_t e;
    fill_src();
    if (v.code != 5'd0) src_data[(int'(v.code) - 1) * DW +: DW] = v.dat;
    @(negedge Clock);
    chk("ready_idle", 32'(rd_ready), 1);
    rd_req = v.req;
    rd_valid = 1'b1;
    if (v.bus) sb.push_back('{v.code, slice(v.code), v.err});
    @(negedge Clock);
    rd_valid = 1'b0;
    chk("ready_encode", 32'(rd_ready), 0);
    @(negedge Clock);
    if (!v.bus) begin
      chk("no_bus_valid", 32'(bus_valid), 0);
      chk("err_flag", 32'(req_err), 32'(v.err));
      chk("ready_after_err", 32'(rd_ready), 1);
      return;
    end
    chk("bus_valid_latency", 32'(bus_valid), 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    chk("bus_code", 32'(bus_code), 32'(e.code));
    chk("bus_out", 32'(bus_out), 32'(e.data));
    chk("req_err", 32'(req_err), 32'(e.err));
    for (int k = 0; k < v.ack_dly; k++) begin
      src_data = ~src_data;
      rd_req = NS'($urandom);
      rd_valid = ~rd_valid;
      @(negedge Clock);
      chk("hold_valid", 32'(bus_valid), 1);
      chk("hold_code", 32'(bus_code), 32'(e.code));
      chk("hold_data", 32'(bus_out), 32'(e.data));
      chk("hold_not_ready", 32'(rd_ready), 0);
    end
    rd_valid = 1'b0;
    bus_ack = 1'b1;
    @(negedge Clock);
    bus_ack = 1'b0;
    chk("ack_valid_low", 32'(bus_valid), 0);
    chk("ack_code_none", 32'(bus_code), 0);
    chk("ack_data_kept", 32'(bus_out), 32'(e.data));
    chk("ack_ready", 32'(rd_ready), 1);
  endtask
  initial begin
    logic [DW-1:0] d0;
    tbl[0] = '{19'h00004, 16'hA5A5, 5, 5'd3, 1'b0, 1'b1};
    tbl[1] = '{19'h40000, 16'h1234, 0, 5'd19, 1'b0, 1'b1};
    tbl[2] = '{19'h00012, 16'hBEEF, 1, 5'd2, 1'b1, 1'b1};
    tbl[3] = '{19'h00100, 16'h0F0F, 2, 5'd9, 1'b0, 1'b1};
    tbl[4] = '{19'h00000, 16'h0000, 0, 5'd0, 1'b1, 1'b0};
    tbl[5] = '{19'h7FFFF, 16'h0000, 0, 5'd0, 1'b1, 1'b0};
    tbl[6] = '{19'h00001, 16'h8001, 0, 5'd1, 1'b0, 1'b1};
    tbl[7] = '{19'h60000, 16'h7E57, 3, 5'd18, 1'b1, 1'b1};
    #2;
    chk("rst_ready", 32'(rd_ready), 1);
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_code", 32'(bus_code), 0);
    chk("rst_out", 32'(bus_out), 0);
    chk("rst_err", 32'(req_err), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    foreach (tbl[i]) run_vec(tbl[i]);
    // back-to-back requests with ack held high: one accepted every 3 cycles
    fill_src();
    bus_ack = 1'b1;
    @(negedge Clock);
    rd_req = 19'h40000;
    rd_valid = 1'b1;
    d0 = slice(5'd19);
    @(negedge Clock);
    rd_valid = 1'b0;
    @(negedge Clock);
    chk("tp_valid1", 32'(bus_valid), 1);
    chk("tp_code1", 32'(bus_code), 19);
    chk("tp_data1", 32'(bus_out), 32'(d0));
    @(negedge Clock);
    chk("tp_ready3", 32'(rd_ready), 1);
    chk("tp_valid_low", 32'(bus_valid), 0);
    rd_req = 19'h00008;
    rd_valid = 1'b1;
    d0 = slice(5'd4);
    @(negedge Clock);
    rd_valid = 1'b0;
    chk("tp_accepted", 32'(rd_ready), 0);
    @(negedge Clock);
    chk("tp_valid2", 32'(bus_valid), 1);
    chk("tp_code2", 32'(bus_code), 4);
    chk("tp_data2", 32'(bus_out), 32'(d0));
    @(negedge Clock);
    bus_ack = 1'b0;
    chk("tp_done", 32'(bus_valid), 0);
    // asynchronous reset between clock edges while driving the bus
    fill_src();
    @(negedge Clock);
    rd_req = 19'h00020;
    rd_valid = 1'b1;
    @(negedge Clock);
    rd_valid = 1'b0;
    @(negedge Clock);
    chk("ar_valid_before", 32'(bus_valid), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus_valid), 0);
    chk("ar_code", 32'(bus_code), 0);
    chk("ar_out", 32'(bus_out), 0);
    chk("ar_ready", 32'(rd_ready), 1);
    @(negedge Clock);
    Reset_n = 1'b1;
    run_vec(tbl[3]);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
